// File: rtl/mips_ctrl_pkg.sv
// Shared encodings, state enum and control-word payload for the multicycle MIPS main control.
// Build option: MIPS_CTRL_JUMP_EN adds the JUMP state.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`ifdef MIPS_CTRL_JUMP_EN
        , S_JUMP = 4'd12
`endif
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-word decoder; ir_write/pc_en also follow mem_ready/zero.
// Build option: MIPS_CTRL_JUMP_EN decodes the JUMP state.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    input  logic   zero_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_en     = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_REXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.pc_en     = zero_i;
            end
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
            S_JUMP: begin
                ctrl_o.pc_src = PCSRC_JUMP;
                ctrl_o.pc_en  = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: state register, dispatch, memory stall watchdog, sticky flags.
// Build option: MIPS_CTRL_JUMP_EN enables the j instruction; otherwise opcode 000010 is illegal.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int unsigned CNT_MAX = (MEM_WAIT_MAX == 0) ? 1 : MEM_WAIT_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    ctrl_t            ctrl;
    logic             ill_q, ill_d, ill_set;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            ill_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ill_q   <= ill_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and opcode dispatch; memory states hold until mem_ready.
    always_comb begin
        state_d = state_q;
        ill_set = 1'b0;
        unique case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default: begin
                        ill_set = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_REXEC:  state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BEQ, S_ADDIWB: state_d = S_FETCH;
`ifdef MIPS_CTRL_JUMP_EN
            S_JUMP:   state_d = S_FETCH;
`endif
            default:  state_d = S_START;
        endcase
    end

    // Consecutive-stall counter saturates; the FSM keeps waiting after a timeout.
    always_comb begin
        cnt_d = cnt_q;
        if (mem_ready) begin
            cnt_d = '0;
        end else if (ctrl.mem_req && (cnt_q != CNT_W'(CNT_MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        ill_d = ill_q | ill_set;
        tmo_d = tmo_q | ((MEM_WAIT_MAX != 0) && (cnt_d == CNT_W'(CNT_MAX)));
    end

    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .zero_i      (zero),
        .ctrl_o      (ctrl)
    );

    assign mem_req     = ctrl.mem_req;
    assign mem_write   = ctrl.mem_write;
    assign iord        = ctrl.iord;
    assign ir_write    = ctrl.ir_write;
    assign pc_en       = ctrl.pc_en;
    assign pc_src      = ctrl.pc_src;
    assign reg_dst     = ctrl.reg_dst;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign reg_write   = ctrl.reg_write;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_op      = ctrl.alu_op;
    assign illegal_op  = ill_q;
    assign mem_timeout = tmo_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle expected control words built from instruction rules.
module tb_mips_mc_control;

    localparam int unsigned WAIT_MAX = 2;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [5:0] op;
    logic       mem_req, mem_write, iord, ir_write, pc_en, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       illegal_op, mem_timeout;

    mips_mc_control #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    logic [16:0] act;
    assign act = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, mem_timeout};

    // Expectation state shared with the compare process
    logic [16:0] exp_w;
    string       exp_tag;
    bit          chk = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_seen = 0;
    int          pin_seq = 0;
    int          pin_done = 0;
    string       pin_tag;
    logic [31:0] pin_got, pin_want;

    // Model state: sticky flags and consecutive-stall count
    bit ill_m, tmo_m;
    int stall_m;

    always @(negedge clk) begin
        if (mem_write) wr_seen++;
        if (chk) begin
            n_chk++;
            if (act !== exp_w) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", exp_tag, act, exp_w);
            end
        end
        if (pin_seq != pin_done) begin
            pin_done = pin_seq;
            n_chk++;
            if (pin_got !== pin_want) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", pin_tag, pin_got, pin_want);
            end
        end
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [14:0] cw(input bit req, input bit wr, input bit ia, input bit irw,
                                       input bit pce, input logic [1:0] pcs, input bit rdst,
                                       input bit m2r, input bit rw, input bit sa,
                                       input logic [1:0] sb, input logic [1:0] aop);
        return {req, wr, ia, irw, pce, pcs, rdst, m2r, rw, sa, sb, aop};
    endfunction

    // Literal check, evaluated at the next negedge
    task automatic pin(input string tag, input logic [31:0] got, input logic [31:0] want);
        pin_tag  = tag;
        pin_got  = got;
        pin_want = want;
        pin_seq++;
    endtask

    // One clock cycle: entered and left at posedge+1
    task automatic cyc(input string tag, input bit rdy, input bit z, input logic [14:0] w);
        mem_ready = rdy;
        zero      = z;
        exp_w     = {w, ill_m, tmo_m};
        exp_tag   = tag;
        chk       = 1'b1;
        @(posedge clk);
        #1;
        if (rdy) stall_m = 0;
        else if (w[14]) stall_m++;
        if (WAIT_MAX != 0 && stall_m >= int'(WAIT_MAX)) tmo_m = 1'b1;
    endtask

    task automatic run(input string name, input logic [5:0] opc, input bit z,
                       input int fst, input int mst);
        bit r;
        op = opc;
        for (int i = 0; i <= fst; i++) begin
            r = (i == fst);
            cyc({name, ":fetch"}, r, rb(), cw(1,0,0,r,r,2'b00,0,0,0,0,2'b01,2'b00));
        end
        cyc({name, ":decode"}, rb(), rb(), cw(0,0,0,0,0,2'b00,0,0,0,0,2'b11,2'b00));
        case (opc)
            6'b100011: begin
                cyc({name, ":addr"}, rb(), rb(), cw(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00));
                for (int i = 0; i <= mst; i++) begin
                    r = (i == mst);
                    cyc({name, ":memrd"}, r, rb(), cw(1,0,1,0,0,2'b00,0,0,0,0,2'b00,2'b00));
                end
                cyc({name, ":memwb"}, rb(), rb(), cw(0,0,0,0,0,2'b00,0,1,1,0,2'b00,2'b00));
            end
            6'b101011: begin
                cyc({name, ":addr"}, rb(), rb(), cw(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00));
                for (int i = 0; i <= mst; i++) begin
                    r = (i == mst);
                    cyc({name, ":memwr"}, r, rb(), cw(1,1,1,0,0,2'b00,0,0,0,0,2'b00,2'b00));
                end
            end
            6'b000000: begin
                cyc({name, ":exec"}, rb(), rb(), cw(0,0,0,0,0,2'b00,0,0,0,1,2'b00,2'b10));
                cyc({name, ":wb"}, rb(), rb(), cw(0,0,0,0,0,2'b00,1,0,1,0,2'b00,2'b00));
            end
            6'b000100:
                cyc({name, ":beq"}, rb(), z, cw(0,0,0,0,z,2'b01,0,0,0,1,2'b00,2'b01));
            6'b001000: begin
                cyc({name, ":exec"}, rb(), rb(), cw(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00));
                cyc({name, ":wb"}, rb(), rb(), cw(0,0,0,0,0,2'b00,0,0,1,0,2'b00,2'b00));
            end
`ifdef MIPS_CTRL_JUMP_EN
            6'b000010:
                cyc({name, ":jump"}, rb(), rb(), cw(0,0,0,0,1,2'b10,0,0,0,0,2'b00,2'b00));
`endif
            default: ill_m = 1'b1;
        endcase
    endtask

    task automatic start_cycle();
        ill_m   = 1'b0;
        tmo_m   = 1'b0;
        stall_m = 0;
        cyc("start", rb(), rb(), 15'd0);
    endtask

    int wr_base;

    initial begin
        rst_n     = 1'b0;
        op        = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #2;
        pin("reset_outputs", 32'(act), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_cycle();

        run("lw",       6'b100011, 1'b0, 0, 0);
        run("rtype",    6'b000000, 1'b0, 0, 0);
        run("beq_taken",6'b000100, 1'b1, 0, 0);
        run("beq_not",  6'b000100, 1'b0, 0, 0);
        run("addi",     6'b001000, 1'b0, 0, 0);
        run("lw_stall", 6'b100011, 1'b0, 1, 1);
        run("sw",       6'b101011, 1'b0, 0, 0);
        wr_base = wr_seen;
        run("sw_stall", 6'b101011, 1'b0, 0, 3);
        pin("sw_write_cycles", 32'(wr_seen - wr_base), 32'd4);
        run("rtype2",   6'b000000, 1'b0, 0, 0);
        run("illegal",  6'b111111, 1'b0, 0, 0);
        pin("illegal_sticky", 32'(illegal_op), 32'd1);
        run("jump",     6'b000010, 1'b0, 0, 0);
        run("addi2",    6'b001000, 1'b0, 1, 0);

        // Async reset while stalled in the data read
        op = 6'b100011;
        cyc("rst_fetch", 1'b1, rb(), cw(1,0,0,1,1,2'b00,0,0,0,0,2'b01,2'b00));
        cyc("rst_decode", rb(), rb(), cw(0,0,0,0,0,2'b00,0,0,0,0,2'b11,2'b00));
        cyc("rst_addr", rb(), rb(), cw(0,0,0,0,0,2'b00,0,0,0,1,2'b10,2'b00));
        cyc("rst_memrd", 1'b0, rb(), cw(1,0,1,0,0,2'b00,0,0,0,0,2'b00,2'b00));
        chk       = 1'b0;
        mem_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        pin("async_reset", 32'(act), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_cycle();
        run("lw_post",  6'b100011, 1'b0, 0, 0);
        run("beq_post", 6'b000100, 1'b1, 0, 0);

        chk = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
